// File: rtl/stack_seq_pkg.sv
// Shared definitions for the stack pointer sequencer: op codes, state encoding,
// stack page default and the byte-count normalisation helper.
package stack_seq_pkg;

   localparam logic [2:0] OP_PUSH = 3'd0;
   localparam logic [2:0] OP_PULL = 3'd1;
   localparam logic [2:0] OP_TXS  = 3'd2;
   localparam logic [2:0] OP_TSX  = 3'd3;

   localparam logic [7:0] STACK_PAGE_DFLT = 8'h01;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PUSH_ADDR = 3'd1,
      ST_PUSH_DEC  = 3'd2,
      ST_PULL_INC  = 3'd3,
      ST_PULL_ADDR = 3'd4,
      ST_XFER      = 3'd5
   } state_t;

   // A zero count still moves one byte; larger requests saturate at the limit.
   function automatic logic [1:0] eff_count(input logic [1:0] count, input logic [1:0] max_bytes);
      logic [1:0] res;
      res = count;
      if (count == 2'd0)
         res = 2'd1;
      else if (count > max_bytes)
         res = max_bytes;
      return res;
   endfunction

endpackage

// File: rtl/stack_seq_shadow.sv
// Shadow copy of the stack pointer used to flag page wrap-around on push/pull;
// only instantiated when STACK_SEQ_WRAP_DETECT_EN is defined.
module stack_seq_shadow (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       dec,
   input  logic       inc,
   input  logic       load,
   input  logic [7:0] sb_snoop,
   output logic       wrap_err
);

   logic [7:0] sp_q;

   always_ff @(posedge clk_2) begin
      if (reset) begin
         sp_q     <= 8'hFF;
         wrap_err <= 1'b0;
      end else if (load) begin
         sp_q     <= sb_snoop;
         wrap_err <= 1'b0;
      end else if (dec) begin
         sp_q <= sp_q - 8'd1;
         if (sp_q == 8'h00)
            wrap_err <= 1'b1;
      end else if (inc) begin
         sp_q <= sp_q + 8'd1;
         if (sp_q == 8'hFF)
            wrap_err <= 1'b1;
      end
   end

endmodule

// File: rtl/stack_sequencer.sv
// Cycle sequencer for the stack pointer: turns one push/pull/TXS/TSX command into
// per-cycle datapath strobes. Optional wrap detection via STACK_SEQ_WRAP_DETECT_EN.
//
// state        | meaning
// ST_IDLE      | waiting for start; rw=1, no strobes
// ST_PUSH_ADDR | S drives ADL, stack page on ADH, write cycle
// ST_PUSH_DEC  | S via SB through ALU-1, reloaded into S
// ST_PULL_INC  | S via SB through ALU+1, reloaded into S
// ST_PULL_ADDR | S drives ADL, stack page on ADH, read cycle
// ST_XFER      | single-cycle X<->S transfer (TXS or TSX)
module stack_sequencer
   import stack_seq_pkg::*;
#(
   parameter int         MAX_BYTES  = 3,
   parameter logic [7:0] STACK_PAGE = STACK_PAGE_DFLT
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] op,
   input  logic [1:0] count,
   input  logic [7:0] sb_snoop,
   output logic       busy,
   output logic       done,
   output logic       s_load,
   output logic       s_s,
   output logic       s_sb,
   output logic       s_adl,
   output logic       adh_en,
   output logic [7:0] adh_out,
   output logic       alu_inc,
   output logic       alu_dec,
   output logic       rw,
   output logic [1:0] byte_idx,
   output logic       x_sb,
   output logic       x_load,
   output logic       wrap_err
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_BYTES);

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [1:0] cnt_q, cnt_d;
   logic [1:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic       last_byte;

   assign last_byte = (idx_q == cnt_q - 2'd1);

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_PUSH;
         cnt_q   <= 2'd1;
         idx_q   <= 2'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start && (op[2] == 1'b0)) begin
               op_d  = op;
               cnt_d = eff_count(count, MAX_CNT);
               idx_d = 2'd0;
               if (op == OP_PUSH)
                  state_d = ST_PUSH_ADDR;
               else if (op == OP_PULL)
                  state_d = ST_PULL_INC;
               else
                  state_d = ST_XFER;
            end
         end
         ST_PUSH_ADDR: state_d = ST_PUSH_DEC;
         ST_PUSH_DEC: begin
            if (last_byte) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_PUSH_ADDR;
            end
         end
         ST_PULL_INC: state_d = ST_PULL_ADDR;
         ST_PULL_ADDR: begin
            if (last_byte) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = ST_PULL_INC;
            end
         end
         ST_XFER: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_load  = 1'b0;
      s_s     = 1'b0;
      s_sb    = 1'b0;
      s_adl   = 1'b0;
      adh_en  = 1'b0;
      alu_inc = 1'b0;
      alu_dec = 1'b0;
      rw      = 1'b1;
      x_sb    = 1'b0;
      x_load  = 1'b0;
      unique case (state_q)
         ST_PUSH_ADDR: begin
            s_adl  = 1'b1;
            adh_en = 1'b1;
            rw     = 1'b0;
         end
         ST_PUSH_DEC: begin
            s_sb    = 1'b1;
            alu_dec = 1'b1;
            s_load  = 1'b1;
            s_s     = 1'b1;
         end
         ST_PULL_INC: begin
            s_sb    = 1'b1;
            alu_inc = 1'b1;
            s_load  = 1'b1;
            s_s     = 1'b1;
         end
         ST_PULL_ADDR: begin
            s_adl  = 1'b1;
            adh_en = 1'b1;
         end
         ST_XFER: begin
            if (op_q == OP_TXS) begin
               x_sb   = 1'b1;
               s_load = 1'b1;
               s_s    = 1'b1;
            end else begin
               s_sb   = 1'b1;
               x_load = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign byte_idx = idx_q;
   assign adh_out  = STACK_PAGE;

`ifdef STACK_SEQ_WRAP_DETECT_EN
   logic shadow_dec, shadow_inc, shadow_load;

   assign shadow_dec  = (state_q == ST_PUSH_DEC);
   assign shadow_inc  = (state_q == ST_PULL_INC);
   assign shadow_load = (state_q == ST_XFER) && (op_q == OP_TXS);

   stack_seq_shadow u_shadow (
      .clk_2    (clk_2),
      .reset    (reset),
      .dec      (shadow_dec),
      .inc      (shadow_inc),
      .load     (shadow_load),
      .sb_snoop (sb_snoop),
      .wrap_err (wrap_err)
   );
`else
   logic unused_snoop;
   assign unused_snoop = ^sb_snoop;
   assign wrap_err     = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: every cycle is compared against a
// schedule-queue reference model, plus table-driven and hand-written sequences.
module tb_stack_sequencer;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [2:0] op = 3'd0;
   logic [1:0] count = 2'd0;
   logic [7:0] sb_snoop = 8'h00;
   logic       busy, done, s_load, s_s, s_sb, s_adl, adh_en, alu_inc, alu_dec, rw;
   logic       x_sb, x_load, wrap_err;
   logic [7:0] adh_out;
   logic [1:0] byte_idx;

   stack_sequencer dut (
      .clk_2(clk_2), .reset(reset), .start(start), .op(op), .count(count),
      .sb_snoop(sb_snoop), .busy(busy), .done(done), .s_load(s_load), .s_s(s_s),
      .s_sb(s_sb), .s_adl(s_adl), .adh_en(adh_en), .adh_out(adh_out),
      .alu_inc(alu_inc), .alu_dec(alu_dec), .rw(rw), .byte_idx(byte_idx),
      .x_sb(x_sb), .x_load(x_load), .wrap_err(wrap_err)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct packed {
      logic s_load, s_s, s_sb, s_adl, adh_en, alu_inc, alu_dec, rw, x_sb, x_load;
   } strobes_t;

   typedef struct packed {
      strobes_t   st;
      logic [1:0] idx;
   } slot_t;

   typedef struct {
      logic [2:0] op;
      logic [1:0] count;
      int         cycles;
   } vec_t;

   slot_t      sched[$];
   logic       exp_done = 1'b0;
   logic [1:0] last_idx = 2'd0;
   int         errors = 0;
   int         checks = 0;
   logic [21:0] obs;

   // Reference strobe patterns, written straight from the command descriptions.
   function automatic strobes_t pat_idle();
      strobes_t v = '0;
      v.rw = 1'b1;
      return v;
   endfunction

   function automatic strobes_t pat_addr(input logic write);
      strobes_t v = '0;
      v.s_adl = 1'b1; v.adh_en = 1'b1; v.rw = ~write;
      return v;
   endfunction

   function automatic strobes_t pat_adjust(input logic up);
      strobes_t v = '0;
      v.s_sb = 1'b1; v.s_load = 1'b1; v.s_s = 1'b1; v.rw = 1'b1;
      v.alu_inc = up; v.alu_dec = ~up;
      return v;
   endfunction

   function automatic strobes_t pat_xfer(input logic txs);
      strobes_t v = '0;
      v.rw = 1'b1;
      if (txs) begin v.x_sb = 1'b1; v.s_load = 1'b1; v.s_s = 1'b1; end
      else     begin v.s_sb = 1'b1; v.x_load = 1'b1; end
      return v;
   endfunction

   function automatic void enqueue(input logic [2:0] o, input logic [1:0] c);
      int n;
      n = (c == 2'd0) ? 1 : int'(c);
      if (n > 3) n = 3;
      if (o == 3'd0) begin
         for (int i = 0; i < n; i++) begin
            sched.push_back({pat_addr(1'b1), 2'(i)});
            sched.push_back({pat_adjust(1'b0), 2'(i)});
         end
      end else if (o == 3'd1) begin
         for (int i = 0; i < n; i++) begin
            sched.push_back({pat_adjust(1'b1), 2'(i)});
            sched.push_back({pat_addr(1'b0), 2'(i)});
         end
      end else begin
         sched.push_back({pat_xfer(o == 3'd2), 2'd0});
      end
   endfunction

   function automatic logic [21:0] expected();
      if (sched.size() > 0)
         return {8'h01, 1'b1, 1'b0, sched[0].idx, sched[0].st};
      return {8'h01, 1'b0, exp_done, last_idx, pat_idle()};
   endfunction

   function automatic void model_step(input logic st, input logic [2:0] o,
                                      input logic [1:0] c, input logic rs);
      if (rs) begin
         sched.delete();
         exp_done = 1'b0;
         last_idx = 2'd0;
      end else if (sched.size() > 0) begin
         last_idx = sched[0].idx;
         void'(sched.pop_front());
         exp_done = (sched.size() == 0);
      end else begin
         exp_done = 1'b0;
         if (st && o <= 3'd3) enqueue(o, c);
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // One clock: compare outputs against the model, then drive the next inputs.
   task automatic tick(input logic st, input logic [2:0] o, input logic [1:0] c, input logic rs);
      @(negedge clk_2);
      obs = {adh_out, busy, done, byte_idx, s_load, s_s, s_sb, s_adl, adh_en,
             alu_inc, alu_dec, rw, x_sb, x_load};
      check("cycle", 32'(obs), 32'(expected()));
      start = st; op = o; count = c; reset = rs;
      model_step(st, o, c, rs);
   endtask

   vec_t table_v[10];

   initial begin
      int busy_n, done_n;
      table_v[0] = '{3'd0, 2'd0, 2};
      table_v[1] = '{3'd0, 2'd1, 2};
      table_v[2] = '{3'd0, 2'd2, 4};
      table_v[3] = '{3'd0, 2'd3, 6};
      table_v[4] = '{3'd1, 2'd0, 2};
      table_v[5] = '{3'd1, 2'd3, 6};
      table_v[6] = '{3'd2, 2'd2, 1};
      table_v[7] = '{3'd3, 2'd1, 1};
      table_v[8] = '{3'd5, 2'd3, 0};
      table_v[9] = '{3'd7, 2'd1, 0};

      // reset then idle
      tick(1'b0, 3'd0, 2'd0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("idle_rw", 32'(obs[2]), 32'd1);
      check("idle_adh", 32'(obs[21:14]), 32'h01);

      // table of single commands: busy length and exactly one done (none if reserved)
      for (int r = 0; r < 10; r++) begin
         tick(1'b1, table_v[r].op, table_v[r].count, 1'b0);
         busy_n = 0; done_n = 0;
         for (int k = 0; k < 9; k++) begin
            tick(1'b0, 3'd0, 2'd0, 1'b0);
            busy_n += int'(obs[13]);
            done_n += int'(obs[12]);
         end
         check("busy_len", 32'(busy_n), 32'(table_v[r].cycles));
         check("done_cnt", 32'(done_n), (table_v[r].cycles > 0) ? 32'd1 : 32'd0);
      end

      // PULL 2 followed by TSX issued in the done cycle
      tick(1'b1, 3'd1, 2'd2, 1'b0);
      for (int k = 0; k < 4; k++) tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b1, 3'd3, 2'd0, 1'b0);
      check("pull_done", 32'(obs[12]), 32'd1);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("tsx_xload", 32'({obs[13], obs[0]}), 32'b11);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("tsx_done", 32'(obs[12]), 32'd1);

      // PUSH 3 interrupted by reset in its third cycle
      tick(1'b1, 3'd0, 2'd3, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b1);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("rst_idle", 32'({obs[13], obs[12], obs[2]}), 32'b001);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("rst_nodone", 32'(obs[12]), 32'd0);

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         sb_snoop = 8'($urandom);
         tick(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom),
              ($urandom_range(0, 63) == 0));
      end
      tick(1'b0, 3'd0, 2'd0, 1'b1);
      tick(1'b0, 3'd0, 2'd0, 1'b0);

`ifdef STACK_SEQ_WRAP_DETECT_EN
      sb_snoop = 8'h01;
      tick(1'b1, 3'd2, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("wrap_txs01", 32'(wrap_err), 32'd0);
      tick(1'b1, 3'd0, 2'd2, 1'b0);
      for (int k = 0; k < 3; k++) tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("wrap_first_dec", 32'(wrap_err), 32'd0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("wrap_push", 32'(wrap_err), 32'd1);
      sb_snoop = 8'hFF;
      tick(1'b1, 3'd2, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("wrap_txsff", 32'(wrap_err), 32'd0);
      tick(1'b1, 3'd1, 2'd1, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      tick(1'b0, 3'd0, 2'd0, 1'b0);
      check("wrap_pull", 32'(wrap_err), 32'd1);
`else
      check("wrap_tied", 32'(wrap_err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
